// File: rtl/pulse_stretcher.sv
// Pulse stretcher: each input event becomes a held-high pulse of high_len cycles,
// separated by at least low_len low cycles, with a saturating queue of pending events.
module pulse_stretcher #(
    parameter int W = 16,
    parameter int P = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         a,
    input  logic [W-1:0] high_len,
    input  logic [W-1:0] low_len,
    input  logic         retrig,
    input  logic         clr_ovf,
    output logic         y,
    output logic         busy,
    output logic [P-1:0] pending,
    output logic         ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [W-1:0] CONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [P-1:0] PONE = {{(P-1){1'b0}}, 1'b1};
    localparam logic [P-1:0] PMAX = '1;

    state_t       state, state_nx;
    logic [W-1:0] cnt, cnt_nx;
    logic [P-1:0] pend_nx;
    logic         ovf_set;
    logic [W-1:0] hl_m1, gl_m1;

    // Zero length behaves as one cycle, so the reload value never underflows
    assign hl_m1 = (high_len == '0) ? '0 : high_len - CONE;
    assign gl_m1 = (low_len == '0) ? '0 : low_len - CONE;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pend_nx  = pending;
        ovf_set  = 1'b0;
        unique case (state)
            IDLE: begin
                if (a) begin
                    state_nx = HIGH;
                    cnt_nx   = hl_m1;
                end
            end
            HIGH: begin
                if (a && retrig) begin
                    cnt_nx = hl_m1;
                end else begin
                    if (a) begin
                        if (pending == PMAX) ovf_set = 1'b1;
                        else pend_nx = pending + PONE;
                    end
                    if (cnt == '0) begin
                        state_nx = GAP;
                        cnt_nx   = gl_m1;
                    end else begin
                        cnt_nx = cnt - CONE;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    // A queued event is launched; a coincident event takes its slot
                    if (pending != '0) begin
                        state_nx = HIGH;
                        cnt_nx   = hl_m1;
                        if (!a) pend_nx = pending - PONE;
                    end else if (a) begin
                        state_nx = HIGH;
                        cnt_nx   = hl_m1;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    cnt_nx = cnt - CONE;
                    if (a) begin
                        if (pending == PMAX) ovf_set = 1'b1;
                        else pend_nx = pending + PONE;
                    end
                end
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            ovf     <= 1'b0;
            y       <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            pending <= pend_nx;
            ovf     <= ovf_set | (ovf & ~clr_ovf);
            y       <= (state_nx == HIGH);
            busy    <= (state_nx != IDLE);
        end
    end

endmodule
